// File: rtl/dom1_skinny_fpga_iobuf_if.sv
// Byte-serial host/core bus for the DOM1 SKINNY I/O buffer.
// master: test protocol FSM plus masked core (drives strobes, result, done).
// slave:  the I/O buffer itself.
interface dom1_skinny_fpga_iobuf_if #(
  parameter int NBYTES = 112
);
  logic [7:0]          di_data;
  logic                iwr;
  logic                ord;
  logic                core_rst;
  logic                core_done;
  logic [8*NBYTES-1:0] core_dout;
  logic [8*NBYTES-1:0] core_din;
  logic [7:0]          do_data;
  logic                full;
  logic                drained;
  logic                err;

  modport master (
    output di_data, iwr, ord, core_rst, core_done, core_dout,
    input  core_din, do_data, full, drained, err
  );

  modport slave (
    input  di_data, iwr, ord, core_rst, core_done, core_dout,
    output core_din, do_data, full, drained, err
  );
endinterface

// File: rtl/dom1_skinny_fpga_iobuf.sv
// Byte-serial I/O buffer between the FPGA test protocol FSM and the masked
// SKINNY-128/384+ core. Host bytes shift in LSB-side; the core sees the whole
// register in parallel (byte 0 = MSB). On core completion the result is
// captured once and shifted back out MSB-first.
//
// Optional build: define DOM1_IOBUF_ZEROIZE_EN to clear the buffer on
// core_rst and on the read that drains the last byte, so key and mask shares
// never linger in the register after use.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_LOAD | no result captured; writes accepted, reads are errors
// ST_CAPT | core result captured; reads shift it out until drained
module dom1_skinny_fpga_iobuf #(
  parameter int NBYTES = 112
) (
  input logic                     clk,
  input logic                     rst,
  dom1_skinny_fpga_iobuf_if.slave bus
);

  localparam int        W      = 8 * NBYTES;
  localparam logic [7:0] NB    = 8'(NBYTES);
  localparam logic [7:0] NB_M1 = 8'(NBYTES - 1);

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_CAPT = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   data_q,  data_d;
  logic [7:0]     wcnt_q,  wcnt_d;
  logic [7:0]     rcnt_q,  rcnt_d;
  logic           err_q,   err_d;

  logic           full_w;
  logic           drained_w;
  logic           cap_ev_w;

  assign full_w    = (wcnt_q == NB);
  assign drained_w = (state_q == ST_CAPT) && (rcnt_q == NB);
  // A write or core restart in the same cycle blocks capture; done is a level,
  // so only the first cycle after entering ST_LOAD's done window captures.
  assign cap_ev_w  = bus.core_done && (state_q == ST_LOAD) && !bus.iwr && !bus.core_rst;

  // State, buffer and counters; everything clears on reset, nothing retained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LOAD;
      data_q  <= '0;
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      err_q   <= err_d;
    end
  end

  // Strobe priority: core_rst, then iwr, then capture, then ord.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    err_d   = err_q;

    if (bus.core_rst) begin
      wcnt_d  = '0;
      rcnt_d  = '0;
      state_d = ST_LOAD;
`ifdef DOM1_IOBUF_ZEROIZE_EN
      data_d  = '0;
`endif
    end else if (bus.iwr) begin
      // Overflowing write still shifts (oldest byte falls off the MSB end).
      data_d = {data_q[W-9:0], bus.di_data};
      if (full_w) begin
        err_d = 1'b1;
      end else begin
        wcnt_d = wcnt_q + 8'd1;
      end
      if (bus.ord) begin
        err_d = 1'b1;
      end
    end else if (cap_ev_w) begin
      data_d  = bus.core_dout;
      state_d = ST_CAPT;
      rcnt_d  = '0;
      if (bus.ord) begin
        err_d = 1'b1;
      end
    end else if (bus.ord) begin
      if ((state_q == ST_LOAD) || drained_w) begin
        err_d = 1'b1;
      end else begin
        data_d = {data_q[W-9:0], 8'h00};
        rcnt_d = rcnt_q + 8'd1;
`ifdef DOM1_IOBUF_ZEROIZE_EN
        if (rcnt_q == NB_M1) begin
          data_d = '0;
        end
`endif
      end
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    bus.core_din = data_q;
    bus.do_data  = data_q[W-1 -: 8];
    bus.full     = full_w;
    bus.drained  = drained_w;
    bus.err      = err_q;
  end

endmodule

// File: tb/tb_dom1_skinny_fpga_iobuf.sv
module tb_dom1_skinny_fpga_iobuf;

  localparam int NB = 112;
  localparam int W  = 8 * NB;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dom1_skinny_fpga_iobuf_if #(.NBYTES(NB)) bus ();

  dom1_skinny_fpga_iobuf #(.NBYTES(NB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  function automatic logic [W-1:0] pat(input logic [7:0] seed);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < NB; k++) r[W-1-8*k -: 8] = seed ^ 8'(k);
    return r;
  endfunction

  task automatic push_pat(input logic [7:0] seed);
    for (int k = 0; k < NB; k++) exp_q.push_back(seed ^ 8'(k));
  endtask

  task automatic check_rd(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd1);
    end else begin
      e = exp_q.pop_front();
      check(tag, 64'(bus.do_data), 64'(e));
    end
  endtask

  task automatic write_bytes(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      bus.iwr = 1'b1;
      bus.di_data = base + 8'(i);
      step();
    end
    bus.iwr = 1'b0;
  endtask

  initial begin
    bus.di_data = '0; bus.iwr = 0; bus.ord = 0; bus.core_rst = 0;
    bus.core_done = 0; bus.core_dout = '0;
    step(); step();
    rst = 1'b0;

    // reset state
    check("rst_din",     64'(|bus.core_din), 64'd0);
    check("rst_do",      64'(bus.do_data), 64'h00);
    check("rst_full",    64'(bus.full), 64'd0);
    check("rst_drained", 64'(bus.drained), 64'd0);
    check("rst_err",     64'(bus.err), 64'd0);

    // load 0x00..0x6F
    write_bytes(NB - 1, 8'h00);
    check("t1_full_111", 64'(bus.full), 64'd0);
    write_bytes(1, 8'h6F);
    check("t1_full",  64'(bus.full), 64'd1);
    check("t1_msb",   64'(bus.core_din[W-1 -: 8]), 64'h00);
    check("t1_lsb",   64'(bus.core_din[7:0]), 64'h6F);
    check("t1_lsb1",  64'(bus.core_din[15:8]), 64'h6E);
    check("t1_err",   64'(bus.err), 64'd0);

    // read with nothing captured: error, no shift
    bus.ord = 1'b1; step(); bus.ord = 1'b0;
    check("ord_nocap_err", 64'(bus.err), 64'd1);
    check("ord_nocap_msb", 64'(bus.core_din[15:0]), 64'h6E6F);

    // async reset mid-load
    do_reset();
    write_bytes(50, 8'h20);
    check("t5_pre_lsb", 64'(bus.core_din[7:0]), 64'h51);
    #2 rst = 1'b1;
    #1;
    check("t5_async_din",  64'(|bus.core_din), 64'd0);
    check("t5_async_do",   64'(bus.do_data), 64'h00);
    check("t5_async_full", 64'(bus.full), 64'd0);
    check("t5_async_err",  64'(bus.err), 64'd0);
    #1 rst = 1'b0;
    write_bytes(NB - 1, 8'h00);
    check("t5_full_111", 64'(bus.full), 64'd0);
    write_bytes(1, 8'h6F);
    check("t5_full_112", 64'(bus.full), 64'd1);

    // core_rst then held core_done; dout changes after first cycle
    bus.core_rst = 1'b1; step(); bus.core_rst = 1'b0;
    check("t2_full_clr", 64'(bus.full), 64'd0);
`ifdef DOM1_IOBUF_ZEROIZE_EN
    check("t2_zero_din", 64'(|bus.core_din), 64'd0);
`else
    check("t2_keep_lsb", 64'(bus.core_din[15:0]), 64'h6E6F);
`endif
    bus.core_done = 1'b1;
    bus.core_dout = pat(8'hA5);
    push_pat(8'hA5);
    step();
    bus.core_dout = '1;
    for (int i = 0; i < 4; i++) step();
    bus.core_done = 1'b0;
    check("t2_lsb_once", 64'(bus.core_din[7:0]), 64'hCA);
    check("t2_drained",  64'(bus.drained), 64'd0);
    check("t2_err",      64'(bus.err), 64'd0);

    // drain all bytes MSB-first
    for (int k = 0; k < NB; k++) begin
      check_rd("t3_rd");
      if (k == NB - 1) check("t3_drained_pre", 64'(bus.drained), 64'd0);
      bus.ord = 1'b1; step(); bus.ord = 1'b0;
    end
    check("t3_drained", 64'(bus.drained), 64'd1);
    check("t3_err",     64'(bus.err), 64'd0);
    check("t3_din_zero", 64'(|bus.core_din), 64'd0);
    bus.ord = 1'b1; step(); bus.ord = 1'b0;
    check("t3_over_err",     64'(bus.err), 64'd1);
    check("t3_over_drained", 64'(bus.drained), 64'd1);

    // capture + ord same cycle, then iwr + ord same cycle
    do_reset();
    bus.core_done = 1'b1; bus.ord = 1'b1;
    bus.core_dout = pat(8'h5A);
    step();
    bus.core_done = 1'b0; bus.ord = 1'b0;
    check("cap_ord_do",  64'(bus.do_data), 64'h5A);
    check("cap_ord_err", 64'(bus.err), 64'd1);
    bus.iwr = 1'b1; bus.ord = 1'b1; bus.di_data = 8'h3C;
    step();
    bus.iwr = 1'b0; bus.ord = 1'b0;
    check("t4_lsb", 64'(bus.core_din[7:0]), 64'h3C);
    check("t4_do",  64'(bus.do_data), 64'h5B);
    check("t4_err", 64'(bus.err), 64'd1);
    for (int k = 0; k < NB - 1; k++) begin
      bus.ord = 1'b1; step(); bus.ord = 1'b0;
    end
    check("t4_no_adv_111", 64'(bus.drained), 64'd0);
    bus.ord = 1'b1; step(); bus.ord = 1'b0;
    check("t4_no_adv_112", 64'(bus.drained), 64'd1);

    // overflow by one write
    do_reset();
    write_bytes(NB, 8'h10);
    check("t6_full_112", 64'(bus.full), 64'd1);
    check("t6_err_112",  64'(bus.err), 64'd0);
    check("t6_msb_112",  64'(bus.core_din[W-1 -: 8]), 64'h10);
    write_bytes(1, 8'h80);
    check("t6_full", 64'(bus.full), 64'd1);
    check("t6_err",  64'(bus.err), 64'd1);
    check("t6_msb",  64'(bus.core_din[W-1 -: 8]), 64'h11);
    check("t6_lsb",  64'(bus.core_din[7:0]), 64'h80);

    // core_rst beats iwr
    bus.core_rst = 1'b1; bus.iwr = 1'b1; bus.di_data = 8'h77;
    step();
    bus.core_rst = 1'b0; bus.iwr = 1'b0;
    check("prio_full", 64'(bus.full), 64'd0);
`ifdef DOM1_IOBUF_ZEROIZE_EN
    check("prio_lsb", 64'(bus.core_din[7:0]), 64'h00);
`else
    check("prio_lsb", 64'(bus.core_din[7:0]), 64'h80);
`endif
    check("prio_err", 64'(bus.err), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
